button_step_gen: RTL and testbench

- Upstream stage of the N-bit up counter.
- Converts a raw, bouncing, asynchronous push-button into a clean single-cycle `step_pulse`, which drives the counter's `enable` input.
- Provides debounce, press-edge detection and optional auto-repeat while the button is held.
- Also exports the debounced button level for status LEDs.

---
 rtl/sync_2ff.sv | 23 ++
 rtl/button_step_gen.sv | 113 +++++++++++
 tb/tb_button_step_gen.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level input.
// Both stages clear to 0 on a synchronous active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1;

  // NOTE: sequential state uses non-blocking assignments so s1 -> q forms two real flop stages.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/button_step_gen.sv
// Push-button front end: synchronise, debounce, detect the press edge and
// optionally auto-repeat, producing one-cycle step pulses for the counter.
module button_step_gen #(
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 25000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic step_pulse,
  output logic btn_level
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PRESS_WAIT   = 3'd1,
    HOLD         = 3'd2,
    REPEAT       = 3'd3,
    RELEASE_WAIT = 3'd4
  } state_t;

  localparam bit             REPEAT_EN   = (REPEAT_DELAY != 0);
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_EN ? REPEAT_DELAY - 1 : 0);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic             btn_sync;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_d;
  logic             level_d;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_in),
    .q     (btn_sync)
  );

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    pulse_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (btn_sync) state_d = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!btn_sync) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end
      end
      HOLD: begin
        if (!btn_sync) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end else if (REPEAT_EN && cnt_q == DELAY_LAST) begin
          state_d = REPEAT;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end
      end
      REPEAT: begin
        if (!btn_sync) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == PERIOD_LAST) begin
          cnt_d   = '0;
          pulse_d = 1'b1;
        end
      end
      RELEASE_WAIT: begin
        // A returning high is a release bounce: back to HOLD with a fresh repeat delay.
        if (btn_sync) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    level_d = (state_d == HOLD) || (state_d == REPEAT) || (state_d == RELEASE_WAIT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      step_pulse <= 1'b0;
      btn_level  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      step_pulse <= pulse_d;
      btn_level  <= level_d;
    end
  end

endmodule

// File: tb/tb_button_step_gen.sv
// Self-checking bench: two instances (auto-repeat on / off) driven by directed
// and random button activity, compared every edge against a debounce model.
module tb_button_step_gen;

  localparam int DEB    = 4;
  localparam int PERIOD = 3;
  localparam int DELAY_V [2] = '{8, 0};

  logic clk = 1'b0;
  logic rst_n;
  logic btn_in;
  logic step_rep, level_rep;
  logic step_norep, level_norep;

  int checks = 0;
  int errors = 0;

  // Reference model state: synchroniser pipe plus, per instance, the debounced
  // level, length of the current disagreeing run, and age of the current hold.
  logic m_s1, m_s2;
  bit   m_lvl [2];
  bit   m_pls [2];
  int   m_run [2];
  int   m_age [2];
  int   n_model [2];
  int   n_dut   [2];

  button_step_gen #(.CNT_W(8), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(8), .REPEAT_PERIOD(PERIOD)) u_rep (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_in     (btn_in),
    .step_pulse (step_rep),
    .btn_level  (level_rep)
  );

  button_step_gen #(.CNT_W(8), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(0), .REPEAT_PERIOD(PERIOD)) u_norep (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_in     (btn_in),
    .step_pulse (step_norep),
    .btn_level  (level_norep)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Level flips after DEB+1 consecutive synchronised samples disagree with it;
  // while held, pulses fall at hold age DELAY, DELAY+PERIOD, DELAY+2*PERIOD, ...
  task automatic model_edge(input logic btn, input logic rn);
    logic s;
    if (!rn) begin
      m_s1 = 1'b0;
      m_s2 = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_lvl[i] = 1'b0; m_pls[i] = 1'b0; m_run[i] = 0; m_age[i] = 0;
      end
    end else begin
      s    = m_s2;
      m_s2 = m_s1;
      m_s1 = btn;
      for (int i = 0; i < 2; i++) begin
        m_pls[i] = 1'b0;
        if (s != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB + 1) begin
            m_lvl[i] = s;
            m_run[i] = 0;
            if (s) begin
              m_pls[i] = 1'b1;
              m_age[i] = 0;
            end
          end
        end else begin
          if (m_lvl[i] && m_run[i] > 0) begin
            m_age[i] = 0;
          end else if (m_lvl[i]) begin
            m_age[i]++;
            if (DELAY_V[i] != 0 &&
                (m_age[i] == DELAY_V[i] ||
                 (m_age[i] > DELAY_V[i] && (m_age[i] - DELAY_V[i]) % PERIOD == 0)))
              m_pls[i] = 1'b1;
          end
          m_run[i] = 0;
        end
        if (m_pls[i]) n_model[i]++;
      end
    end
  endtask

  task automatic cycle(input logic btn, input logic rn);
    btn_in = btn;
    rst_n  = rn;
    @(posedge clk);
    model_edge(btn, rn);
    #1;
    check("rep_pulse",   step_rep,    m_pls[0]);
    check("rep_level",   level_rep,   m_lvl[0]);
    check("norep_pulse", step_norep,  m_pls[1]);
    check("norep_level", level_norep, m_lvl[1]);
    if (step_rep)   n_dut[0]++;
    if (step_norep) n_dut[1]++;
    @(negedge clk);
  endtask

  task automatic hold_for(input logic btn, input int n);
    for (int i = 0; i < n; i++) cycle(btn, 1'b1);
  endtask

  initial begin
    int first;
    int base;
    btn_in = 1'b1;
    rst_n  = 1'b0;
    n_model = '{0, 0};
    n_dut   = '{0, 0};
    @(negedge clk);

    // Reset held with the button pressed: outputs stay low.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0);
      check("reset_pulse", step_rep, 1'b0);
      check("reset_level", level_rep, 1'b0);
    end

    // First press pulse lands 6 edges after reset release; auto-repeat follows.
    first = -1;
    for (int e = 0; e < 30; e++) begin
      cycle(1'b1, 1'b1);
      if (step_rep && first < 0) first = e;
    end
    check("press_latency", first, 6);
    check("repeat_pulses_30", n_dut[0], 7);
    check("norep_pulses_30", n_dut[1], 1);
    hold_for(1'b0, 15);
    check("released_level", level_rep, 1'b0);

    // Press bounce 1,1,0 never reaches the debounce threshold.
    base = n_dut[0];
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b1);
      cycle(1'b1, 1'b1);
      cycle(1'b0, 1'b1);
    end
    hold_for(1'b0, 10);
    check("bounce_no_pulse", n_dut[0] - base, 0);

    // Single-cycle release glitch during HOLD restarts the repeat delay.
    hold_for(1'b1, 12);
    cycle(1'b0, 1'b1);
    hold_for(1'b1, 20);
    check("glitch_level", level_rep, 1'b1);
    hold_for(1'b0, 12);

    // Reset for one edge in the middle of auto-repeat, then press again.
    hold_for(1'b1, 20);
    cycle(1'b1, 1'b0);
    check("midreset_pulse", step_rep, 1'b0);
    check("midreset_level", level_rep, 1'b0);
    first = -1;
    for (int e = 0; e < 12; e++) begin
      cycle(1'b1, 1'b1);
      if (step_rep && first < 0) first = e;
    end
    check("midreset_latency", first, 6);
    hold_for(1'b0, 12);

    // Random bouncing segments with occasional resets.
    for (int seg = 0; seg < 300; seg++) begin
      logic v;
      int   len;
      v   = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 12));
      if ($urandom_range(0, 99) < 3) cycle(v, 1'b0);
      hold_for(v, len);
    end
    hold_for(1'b0, 20);

    check("rep_pulse_total",   n_dut[0], n_model[0]);
    check("norep_pulse_total", n_dut[1], n_model[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
